// File: rtl/wsp_scan_master.sv
// -----------------------------------------------------------------------------
// wsp_scan_master
//
// Initiator side of an IEEE 1500 Wrapper Serial Port. Takes one scan command
// at a time, then runs CAPTURE -> SHIFT(len) -> UPDATE on the wrapper by
// driving the WSC strobes and WSI, collects WSO, and returns the shifted-out
// bits on a valid/ready response channel.
//
// Optional feature (macro WSP_SCAN_CNT_EN): adds output scan_cnt[15:0], a
// wrapping count of UPDATE cycles. Without the macro the port is absent.
//
// Ports
//   wrck       in   wrapper clock, all logic on posedge
//   wrst       in   synchronous active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  master idle; command taken on cmd_valid & cmd_ready
//   cmd_wir    in   1 = instruction scan (WIR), 0 = data scan
//   cmd_len    in   bits to shift, 0..MAX_LEN (larger values are clamped)
//   cmd_data   in   shift-in data, bit 0 shifted first
//   rsp_valid  out  response available, held until rsp_ready
//   rsp_ready  in   response consumer ready
//   rsp_data   out  captured WSO bits, bit 0 = first bit out, bits >= len are 0
//   selectwir  out  WSC SelectWIR
//   capturewr  out  WSC CaptureWR
//   shiftwr    out  WSC ShiftWR
//   updatewr   out  WSC UpdateWR
//   wsi        out  serial data to the wrapper
//   wso        in   serial data from the wrapper (changes on negedge wrck)
//   scan_cnt   out  [WSP_SCAN_CNT_EN only] UPDATE cycle counter
// -----------------------------------------------------------------------------
module wsp_scan_master #(
  parameter  int MAX_LEN = 32,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               wrck,
  input  logic               wrst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_wir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               selectwir,
  output logic               capturewr,
  output logic               shiftwr,
  output logic               updatewr,
  output logic               wsi,
  input  logic               wso
`ifdef WSP_SCAN_CNT_EN
  ,
  output logic [15:0]        scan_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_UPDATE,
    S_RESP
  } state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] rsp_data_q;
  logic               rsp_valid_q;
  logic               cmd_ready_q;
  logic               selectwir_q;
  logic               capturewr_q;
  logic               shiftwr_q;
  logic               updatewr_q;
  logic               wsi_q;
`ifdef WSP_SCAN_CNT_EN
  logic [15:0]        scan_cnt_q;
`endif

  // Length to latch on acceptance, clamped to the register width.
  logic [LEN_W-1:0] len_d;
  always_comb begin
    len_d = cmd_len;
    if (cmd_len > LEN_W'(MAX_LEN)) begin
      len_d = LEN_W'(MAX_LEN);
    end
  end

  always_ff @(posedge wrck) begin
    if (wrst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      selectwir_q <= 1'b0;
      capturewr_q <= 1'b0;
      shiftwr_q   <= 1'b0;
      updatewr_q  <= 1'b0;
      wsi_q       <= 1'b0;
`ifdef WSP_SCAN_CNT_EN
      scan_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            len_q       <= len_d;
            data_q      <= cmd_data;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            cmd_ready_q <= 1'b0;
            selectwir_q <= cmd_wir;
            capturewr_q <= 1'b1;
            state_q     <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          capturewr_q <= 1'b0;
          if (len_q == '0) begin
            updatewr_q <= 1'b1;
            state_q    <= S_UPDATE;
          end else begin
            // First shift bit goes out in the cycle right after capture.
            shiftwr_q <= 1'b1;
            wsi_q     <= data_q[0];
            data_q    <= data_q >> 1;
            state_q   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          // The wrapper presented bit cnt_q on the preceding negedge; take it
          // now, at the edge that ends shift cycle cnt_q.
          rsp_data_q <= rsp_data_q | (MAX_LEN'(wso) << cnt_q);
          if (cnt_q == len_q - LEN_W'(1)) begin
            shiftwr_q  <= 1'b0;
            wsi_q      <= 1'b0;
            updatewr_q <= 1'b1;
            state_q    <= S_UPDATE;
          end else begin
            wsi_q  <= data_q[0];
            data_q <= data_q >> 1;
            cnt_q  <= cnt_q + LEN_W'(1);
          end
        end

        S_UPDATE: begin
          updatewr_q  <= 1'b0;
          selectwir_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
`ifdef WSP_SCAN_CNT_EN
          scan_cnt_q  <= scan_cnt_q + 16'd1;
`endif
        end

        S_RESP: begin
          // A command offered during the handshake waits for IDLE.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign selectwir = selectwir_q;
  assign capturewr = capturewr_q;
  assign shiftwr   = shiftwr_q;
  assign updatewr  = updatewr_q;
  assign wsi       = wsi_q;
`ifdef WSP_SCAN_CNT_EN
  assign scan_cnt  = scan_cnt_q;
`endif

endmodule

// File: tb/tb_wsp_scan_master.sv
// Bench for wsp_scan_master. A behavioural wrapper chain (length and capture
// value set per scan) sits on wsi/wso; expected responses are pushed to a
// queue when a command is driven and popped at the response handshake.
module tb_wsp_scan_master;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               wrck = 1'b0;
  logic               wrst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_wir = 1'b0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               selectwir, capturewr, shiftwr, updatewr, wsi;
  logic               wso = 1'b0;
`ifdef WSP_SCAN_CNT_EN
  logic [15:0]        scan_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [MAX_LEN-1:0] exp_q[$];

  // Wrapper chain model
  int                 mdl_len = 1;
  logic [MAX_LEN-1:0] mdl_cap = '0;
  logic [MAX_LEN-1:0] mdl_reg = '0;

  // Command offered during the handshake of a chained scan
  logic               nxt_wir = 1'b0;
  int                 nxt_len = 0;
  logic [MAX_LEN-1:0] nxt_data = '0;

  wsp_scan_master #(.MAX_LEN(MAX_LEN)) dut (
    .wrck(wrck), .wrst(wrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wir(cmd_wir),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .selectwir(selectwir), .capturewr(capturewr), .shiftwr(shiftwr),
    .updatewr(updatewr), .wsi(wsi), .wso(wso)
`ifdef WSP_SCAN_CNT_EN
    , .scan_cnt(scan_cnt)
`endif
  );

  always #5 wrck = ~wrck;

  function automatic logic [MAX_LEN-1:0] chain_shift(input logic [MAX_LEN-1:0] r, input logic b);
    logic [MAX_LEN-1:0] t;
    t = r >> 1;
    t[mdl_len-1] = b;
    return t;
  endfunction

  always @(posedge wrck) begin
    if (capturewr) mdl_reg <= mdl_cap;
    else if (shiftwr) mdl_reg <= chain_shift(mdl_reg, wsi);
  end
  always @(negedge wrck) wso <= mdl_reg[0];

  function automatic logic [MAX_LEN-1:0] mask_n(input logic [MAX_LEN-1:0] v, input int n);
    logic [MAX_LEN-1:0] r;
    r = '0;
    for (int k = 0; k < n && k < MAX_LEN; k++) r[k] = v[k];
    return r;
  endfunction

  // Output of an l-bit chain that captured cap, after shifting n bits of d.
  function automatic logic [MAX_LEN-1:0] exp_rsp(input int l, input logic [MAX_LEN-1:0] cap,
                                                 input logic [MAX_LEN-1:0] d, input int n);
    logic [MAX_LEN-1:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = (k < l) ? cap[k] : d[k-l];
    return r;
  endfunction

  task automatic apply_reset();
    wrst = 1'b1;
    repeat (2) @(posedge wrck);
    @(negedge wrck);
    wrst = 1'b0;
  endtask

  // One full command/response transaction with per-cycle WSC checks.
  task automatic scan(input string name, input logic wir, input int len,
                      input logic [MAX_LEN-1:0] data, input logic [MAX_LEN-1:0] exp,
                      input int hold, input logic chained, input logic offer_next);
    int n, c, ncap, nsh, nupd, nsel, nbad, cap_at, upd_at, sbad;
    logic [MAX_LEN-1:0] wsi_seen, held, want;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    ncap = 0; nsh = 0; nupd = 0; nsel = 0; nbad = 0; cap_at = -1; upd_at = -1; sbad = 0;
    c = MAX_LEN + 12;
    wsi_seen = '0;
    exp_q.push_back(exp);
    if (!chained) @(negedge wrck);
    checks++;
    if (cmd_ready !== 1'b1 || capturewr !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_before_accept: cmd_ready=%b capturewr=%b want 1/0", name, cmd_ready, capturewr);
    end
    cmd_valid = 1'b1; cmd_wir = wir; cmd_len = LEN_W'(len); cmd_data = data;
    @(posedge wrck);
    #1;
    cmd_valid = 1'b0; cmd_wir = 1'b0; cmd_len = '0; cmd_data = '0;
    for (int i = 0; i < MAX_LEN + 12; i++) begin
      @(negedge wrck);
      if (rsp_valid === 1'b1) begin c = i; break; end
      if (capturewr) begin ncap++; cap_at = i; end
      if (shiftwr) begin if (nsh < MAX_LEN) wsi_seen[nsh] = wsi; nsh++; end
      if (updatewr) begin nupd++; upd_at = i; end
      if (selectwir) nsel++;
      if (int'(capturewr) + int'(shiftwr) + int'(updatewr) > 1 || (!shiftwr && wsi) || cmd_ready) nbad++;
    end
    $display("%s: wir=%0b len=%0d data=%h -> rsp_data=%h after %0d cycles", name, wir, len, data, rsp_data, c);
    // Counting the accept cycle itself, this is the len+3 cycle latency.
    checks++;
    if (c != n + 2) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, c, n + 2); end
    checks++;
    if (ncap != 1 || cap_at != 0) begin errors++; $display("FAIL %s capture: count %0d at %0d want 1 at 0", name, ncap, cap_at); end
    checks++;
    if (nsh != n) begin errors++; $display("FAIL %s shift_cycles: got %0d want %0d", name, nsh, n); end
    checks++;
    if (nupd != 1 || upd_at != n + 1) begin errors++; $display("FAIL %s update: count %0d at %0d want 1 at %0d", name, nupd, upd_at, n + 1); end
    checks++;
    if (nsel != (wir ? n + 2 : 0)) begin errors++; $display("FAIL %s selectwir_cycles: got %0d want %0d", name, nsel, wir ? n + 2 : 0); end
    want = mask_n(data, n);
    checks++;
    if (wsi_seen !== want) begin errors++; $display("FAIL %s wsi_seq: got %h want %h", name, wsi_seen, want); end
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL %s wsc_exclusive: got %0d bad cycles want 0", name, nbad); end
    held = rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge wrck);
      if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 ||
          selectwir || capturewr || shiftwr || updatewr || wsi) sbad++;
    end
    if (hold > 0) begin
      checks++;
      if (sbad != 0) begin errors++; $display("FAIL %s backpressure_stable: got %0d bad cycles want 0", name, sbad); end
    end
    rsp_ready = 1'b1;
    if (offer_next) begin
      cmd_valid = 1'b1; cmd_wir = nxt_wir; cmd_len = LEN_W'(nxt_len); cmd_data = nxt_data;
    end
    @(posedge wrck);
    #1;
    rsp_ready = 1'b0;
    want = exp_q.pop_front();
    checks++;
    if (held !== want) begin errors++; $display("FAIL %s rsp_data: got %h want %h", name, held, want); end
    @(negedge wrck);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_handshake: cmd_ready=%b rsp_valid=%b want 1/0", name, cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    $display("reset: cmd_ready=%b rsp_valid=%b rsp_data=%h", cmd_ready, rsp_valid, rsp_data);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
      errors++; $display("FAIL reset_rsp: valid=%b data=%h want 0/0", rsp_valid, rsp_data);
    end
    checks++;
    if ({selectwir, capturewr, shiftwr, updatewr, wsi} !== 5'b0) begin
      errors++; $display("FAIL reset_wsc: got %b want 00000", {selectwir, capturewr, shiftwr, updatewr, wsi});
    end
  endtask

  task automatic test_wir_load();
    mdl_len = 4; mdl_cap = 32'h6;
    scan("wir_load", 1'b1, 4, 32'hA, 32'h6, 0, 1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    mdl_len = 1; mdl_cap = '0;
    scan("bypass", 1'b0, 8, 32'hA5, 32'h4A, 0, 1'b0, 1'b0);
  endtask

  task automatic test_boundaries();
    logic [MAX_LEN-1:0] cap, d;
    mdl_len = 4; mdl_cap = 32'h9;
    scan("len_zero", 1'b1, 0, 32'hFFFF_FFFF, '0, 0, 1'b0, 1'b0);
    cap = $urandom(); d = $urandom();
    mdl_len = MAX_LEN; mdl_cap = cap;
    scan("len_clamp", 1'b0, MAX_LEN + 5, d, cap, 0, 1'b0, 1'b0);
    mdl_len = 3; mdl_cap = 32'h5; d = $urandom();
    scan("len_max", 1'b1, MAX_LEN, d, exp_rsp(3, 32'h5, d, MAX_LEN), 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    mdl_len = 2; mdl_cap = 32'h2;
    scan("backpressure", 1'b0, 6, 32'h2D, exp_rsp(2, 32'h2, 32'h2D, 6), 10, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int l, len;
    logic wir;
    logic [MAX_LEN-1:0] cap, d;
    for (int t = 0; t < 4; t++) begin
      l = $urandom_range(1, 8);
      len = $urandom_range(1, MAX_LEN);
      wir = 1'($urandom_range(0, 1));
      cap = mask_n($urandom(), l);
      d = $urandom();
      mdl_len = l; mdl_cap = cap;
      scan("random", wir, len, d, exp_rsp(l, cap, d, len), t, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    mdl_len = 1; mdl_cap = 32'h1;
    nxt_wir = 1'b1; nxt_len = 3; nxt_data = 32'h6;
    scan("b2b_first", 1'b0, 5, 32'h13, exp_rsp(1, 32'h1, 32'h13, 5), 0, 1'b0, 1'b1);
    mdl_len = 4; mdl_cap = 32'hC;
    scan("b2b_second", 1'b1, 3, 32'h6, exp_rsp(4, 32'hC, 32'h6, 3), 0, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    int upd, busy;
    mdl_len = 4; mdl_cap = 32'h3;
    @(negedge wrck);
    cmd_valid = 1'b1; cmd_wir = 1'b1; cmd_len = LEN_W'(8); cmd_data = 32'hFF;
    @(posedge wrck);
    #1;
    cmd_valid = 1'b0; cmd_len = '0; cmd_data = '0; cmd_wir = 1'b0;
    repeat (3) @(negedge wrck);
    checks++;
    if (shiftwr !== 1'b1) begin errors++; $display("FAIL mid_reset_in_shift: shiftwr=%b want 1", shiftwr); end
    wrst = 1'b1;
    @(posedge wrck);
    @(negedge wrck);
    $display("mid_reset: wsc=%b cmd_ready=%b", {selectwir, capturewr, shiftwr, updatewr, wsi}, cmd_ready);
    checks++;
    if ({selectwir, capturewr, shiftwr, updatewr, wsi} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_wsc: got %b want 00000", {selectwir, capturewr, shiftwr, updatewr, wsi});
    end
    @(posedge wrck);
    @(negedge wrck);
    wrst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_cmd_ready: got %b want 1", cmd_ready); end
    upd = 0; busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge wrck);
      if (updatewr) upd++;
      if (rsp_valid || capturewr || shiftwr || !cmd_ready) busy++;
    end
    checks++;
    if (upd != 0 || busy != 0) begin
      errors++; $display("FAIL mid_reset_quiet: updatewr cycles %0d busy cycles %0d want 0/0", upd, busy);
    end
  endtask

`ifdef WSP_SCAN_CNT_EN
  task automatic test_scan_cnt();
    apply_reset();
    mdl_len = 1; mdl_cap = '0;
    for (int t = 0; t < 3; t++) scan("cnt", 1'b0, 2, 32'h1, exp_rsp(1, '0, 32'h1, 2), 0, 1'b0, 1'b0);
    checks++;
    if (scan_cnt !== 16'd3) begin errors++; $display("FAIL scan_cnt_three: got %0d want 3", scan_cnt); end
    dut.scan_cnt_q = 16'hFFFF;
    scan("cnt_wrap", 1'b0, 0, '0, '0, 0, 1'b0, 1'b0);
    checks++;
    if (scan_cnt !== 16'd0) begin errors++; $display("FAIL scan_cnt_wrap: got %h want 0000", scan_cnt); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wir_load();
    test_bypass();
    test_boundaries();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_mid_reset();
`ifdef WSP_SCAN_CNT_EN
    test_scan_cnt();
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
